// File: rtl/uvmt_sb_st_rst_cond_if.sv
// Bundle between the reset conditioner and its consumers: software request in,
// conditioned reset, completion pulse, request counter and debug state out.
interface uvmt_sb_st_rst_cond_if #(
    parameter int CNT_W = 8
);
    logic             sw_reset_req;
    logic             rst_out;
    logic             rst_n_out;
    logic             init_done;
    logic [CNT_W-1:0] sw_reset_count;
    logic [1:0]       state_o;

    modport master (
        output sw_reset_req,
        input  rst_out,
        input  rst_n_out,
        input  init_done,
        input  sw_reset_count,
        input  state_o
    );

    modport slave (
        input  sw_reset_req,
        output rst_out,
        output rst_n_out,
        output init_done,
        output sw_reset_count,
        output state_o
    );
endinterface

// File: rtl/uvmt_sb_st_rst_cond.sv
// Reset conditioner: async assert, synchronized and stretched deassert,
// software-requested reset with a saturating request counter.
//
// state  | meaning
// ASSERT | raw reset seen; waiting for the deassertion synchronizer to fill
// HOLD   | synchronizer done or sw request taken; counting HOLD_CYCLES edges
// RUN    | rst_out released; sw requests accepted and counted
module uvmt_sb_st_rst_cond #(
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 16,
    parameter int CNT_W       = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    uvmt_sb_st_rst_cond_if.slave       bus
);

    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

    localparam logic [1:0] ST_ASSERT = 2'd0;
    localparam logic [1:0] ST_HOLD   = 2'd1;
    localparam logic [1:0] ST_RUN    = 2'd2;

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_FULL = HOLD_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $fatal(1, "uvmt_sb_st_rst_cond: SYNC_STAGES must be >= 2");
    end
    if (HOLD_CYCLES < 1) begin : g_bad_hold
        $fatal(1, "uvmt_sb_st_rst_cond: HOLD_CYCLES must be >= 1");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic [1:0]             state_q;
    logic [HOLD_W-1:0]      hold_q;
    logic                   rst_q;
    logic                   done_q;
    logic [CNT_W-1:0]       count_q;

    logic sync_fill;
    logic hold_last;

    // The chain MSB lands on the edge after sync_q[SYNC_STAGES-2] is set, so
    // looking one bit down lets the FSM leave ASSERT on that very edge.
    assign sync_fill = sync_q[SYNC_STAGES-2];
    assign hold_last = (hold_q == HOLD_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else if (!sync_q[SYNC_STAGES-1]) begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_ASSERT;
            hold_q  <= '0;
            rst_q   <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_ASSERT: begin
                    if (sync_fill) begin
                        state_q <= ST_HOLD;
                        hold_q  <= '0;
                    end
                end
                ST_HOLD: begin
                    if (bus.sw_reset_req) begin
                        hold_q <= '0;
                    end else if (hold_last) begin
                        state_q <= ST_RUN;
                        hold_q  <= HOLD_FULL;
                        rst_q   <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        hold_q <= hold_q + HOLD_W'(1);
                    end
                end
                ST_RUN: begin
                    if (bus.sw_reset_req) begin
                        state_q <= ST_HOLD;
                        hold_q  <= '0;
                        rst_q   <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_ASSERT;
                    hold_q  <= '0;
                    rst_q   <= 1'b1;
                end
            endcase
        end
    end

    // Only requests that actually pull the system out of RUN are counted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (state_q == ST_RUN && bus.sw_reset_req && count_q != CNT_MAX) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign bus.rst_out        = rst_q;
    assign bus.rst_n_out      = ~rst_q;
    assign bus.init_done      = done_q;
    assign bus.sw_reset_count = count_q;
    assign bus.state_o        = state_q;

endmodule
